fp_vector_checker: RTL and testbench

FP_VECTOR_CHECKER -- requirements
Module: fp_vector_checker

---
 rtl/fpchk_pkg.sv | 26 ++
 rtl/fpchk_delay.sv | 32 +++
 rtl/fp_vector_checker.sv | 197 +++++++++++++++++++
 tb/tb_fp_vector_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpchk_pkg.sv
// Shared types and vector layout for the FP vector checker.
// A vector is {op1, op2, y_expected, flags_expected[7:0]}, msb first.
package fpchk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } fpchk_state_e;

    localparam int FLEN_SP   = 32;
    localparam int FLEN_DP   = 64;
    localparam int FLAGS_LSB = 0;
    localparam int FLAGS_W   = 8;
    localparam int Y_LSB     = 8;

    function automatic int op2_lsb(input int flen);
        return flen + FLAGS_W;
    endfunction

    function automatic int op1_lsb(input int flen);
        return 2 * flen + FLAGS_W;
    endfunction

endpackage

// File: rtl/fpchk_delay.sv
// Fixed-latency delay line; DEPTH of zero degenerates to a plain wire.
module fpchk_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_s;
            assign unused_s = clk ^ reset;
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] pipe_r [DEPTH];

            // Shift register, cleared by reset so in-flight entries are dropped
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) pipe_r[i] <= '0;
                end else begin
                    pipe_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
                end
            end

            assign q = pipe_r[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/fp_vector_checker.sv
// Streams test vectors to an FP unit, compares its results and counts mismatches.
// Define FPCHK_FLAGS_CHECK_EN to also compare dut_flags against flags_expected[4:0].
module fp_vector_checker
    import fpchk_pkg::*;
#(
    parameter int  FLEN    = 32,
    parameter int  DUT_LAT = 0,
    parameter int  AW      = 16,
    localparam int VW      = 3 * FLEN + 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     num_vec,
    input  logic [2:0]      rm_cfg,
    input  logic [2:0]      op_type_cfg,
    output logic            vec_rd,
    output logic [AW-1:0]   vec_addr,
    input  logic [VW-1:0]   vec_data,
    output logic            dut_valid,
    output logic [FLEN-1:0] dut_op1,
    output logic [FLEN-1:0] dut_op2,
    output logic [2:0]      dut_rm,
    output logic [2:0]      dut_op_type,
    input  logic [FLEN-1:0] dut_result,
    input  logic [4:0]      dut_flags,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     vec_count,
    output logic [31:0]     err_count,
    output logic            err_valid,
    output logic [AW-1:0]   err_index,
    output logic [FLEN-1:0] err_result,
    output logic [FLEN-1:0] err_expected
);
    localparam int OP1_LSB = op1_lsb(FLEN);
    localparam int OP2_LSB = op2_lsb(FLEN);
    localparam int DW      = 1 + FLEN + FLAGS_W + AW;

    fpchk_state_e   state_r, state_nxt_s;
    logic [AW:0]    num_vec_r, vec_count_r, cnt_inc_s;
    logic [2:0]     rm_r, op_type_r;
    logic           busy_r, done_r, vec_rd_r, rd_d1_r, dut_valid_r;
    logic [AW-1:0]  vec_addr_r, idx_d1_r, idx_r;
    logic [FLEN-1:0] op1_r, op2_r, y_exp_r;
    logic [FLAGS_W-1:0] flags_exp_r;
    logic [31:0]    err_count_r;
    logic           err_valid_r;
    logic [AW-1:0]  err_index_r;
    logic [FLEN-1:0] err_result_r, err_expected_r;

    logic           start_ok_s, last_rd_s, last_cmp_s, mismatch_s, unused_s;
    logic           cmp_valid_s;
    logic [FLEN-1:0] cmp_y_s;
    logic [FLAGS_W-1:0] cmp_flags_s;
    logic [AW-1:0]  cmp_idx_s;

    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_rd_s  = vec_rd_r && ({1'b0, vec_addr_r} == (num_vec_r - (AW+1)'(1)));
    assign cnt_inc_s  = vec_count_r + (AW+1)'(1);
    assign last_cmp_s = cmp_valid_s && (cnt_inc_s == num_vec_r);

    // Expected values and index ride alongside dut_valid for DUT_LAT cycles
    fpchk_delay #(.W(DW), .DEPTH(DUT_LAT)) u_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({dut_valid_r, y_exp_r, flags_exp_r, idx_r}),
        .q     ({cmp_valid_s, cmp_y_s, cmp_flags_s, cmp_idx_s})
    );

`ifdef FPCHK_FLAGS_CHECK_EN
    assign mismatch_s = cmp_valid_s &&
                        ((dut_result !== cmp_y_s) || (dut_flags !== cmp_flags_s[4:0]));
    assign unused_s   = ^cmp_flags_s[7:5];
`else
    assign mismatch_s = cmp_valid_s && (dut_result !== cmp_y_s);
    assign unused_s   = ^{dut_flags, cmp_flags_s};
`endif

    // Next-state logic for the run sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    if (num_vec == '0) state_nxt_s = DONE;
                    else               state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            STREAM: begin
                if (last_rd_s) state_nxt_s = DRAIN;
                else           state_nxt_s = STREAM;
            end
            DRAIN: begin
                if (last_cmp_s) state_nxt_s = DONE;
                else            state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state, latched run configuration, read strobe and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            num_vec_r   <= '0;
            rm_r        <= 3'd0;
            op_type_r   <= 3'd0;
            vec_rd_r    <= 1'b0;
            vec_addr_r  <= '0;
            vec_count_r <= '0;
            err_count_r <= 32'd0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s == STREAM) || (state_nxt_s == DRAIN);
            done_r   <= (state_nxt_s == DONE);
            vec_rd_r <= (state_nxt_s == STREAM);
            // Address restarts at 0 on entry to STREAM and parks at 0 otherwise
            vec_addr_r <= ((state_r == STREAM) && (state_nxt_s == STREAM)) ?
                          vec_addr_r + AW'(1) : '0;
            if (start_ok_s) begin
                num_vec_r   <= num_vec;
                rm_r        <= rm_cfg;
                op_type_r   <= op_type_cfg;
                vec_count_r <= '0;
                err_count_r <= 32'd0;
            end else if (cmp_valid_s) begin
                vec_count_r <= cnt_inc_s;
                if (mismatch_s && (err_count_r != 32'hFFFF_FFFF)) begin
                    err_count_r <= err_count_r + 32'd1;
                end
            end
        end
    end

    // Vector return path: data arrives one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_d1_r     <= 1'b0;
            idx_d1_r    <= '0;
            dut_valid_r <= 1'b0;
            op1_r       <= '0;
            op2_r       <= '0;
            y_exp_r     <= '0;
            flags_exp_r <= '0;
            idx_r       <= '0;
        end else begin
            rd_d1_r     <= vec_rd_r;
            idx_d1_r    <= vec_addr_r;
            dut_valid_r <= rd_d1_r;
            if (rd_d1_r) begin
                op1_r       <= vec_data[OP1_LSB +: FLEN];
                op2_r       <= vec_data[OP2_LSB +: FLEN];
                y_exp_r     <= vec_data[Y_LSB +: FLEN];
                flags_exp_r <= vec_data[FLAGS_LSB +: FLAGS_W];
                idx_r       <= idx_d1_r;
            end
        end
    end

    // Mismatch report, one-cycle pulse with the offending vector's details
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_r    <= 1'b0;
            err_index_r    <= '0;
            err_result_r   <= '0;
            err_expected_r <= '0;
        end else begin
            err_valid_r <= mismatch_s;
            if (mismatch_s) begin
                err_index_r    <= cmp_idx_s;
                err_result_r   <= dut_result;
                err_expected_r <= cmp_y_s;
            end
        end
    end

    assign vec_rd       = vec_rd_r;
    assign vec_addr     = vec_addr_r;
    assign dut_valid    = dut_valid_r;
    assign dut_op1      = op1_r;
    assign dut_op2      = op2_r;
    assign dut_rm       = rm_r;
    assign dut_op_type  = op_type_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign vec_count    = vec_count_r;
    assign err_count    = err_count_r;
    assign err_valid    = err_valid_r;
    assign err_index    = err_index_r;
    assign err_result   = err_result_r;
    assign err_expected = err_expected_r;
endmodule

// File: tb/tb_fp_vector_checker.sv
// Bench for fp_vector_checker: two instances (DUT_LAT 0 and 3) share stimulus;
// a fake FP unit returns op1^op2, with optional wrong result at a chosen index.
module tb_fp_vector_checker;
    import fpchk_pkg::*;

    localparam int FLEN = 32;
    localparam int AW   = 6;
    localparam int VW   = 3 * FLEN + 8;
    localparam int LAT1 = 3;
    localparam int NMAX = 64;

    typedef struct {
        int n; int rm; int op; int pat; int bad; int fbad; bit poke;
    } case_t;

    typedef struct {
        int idx; logic [31:0] res; logic [31:0] exp;
    } err_rec_t;

    logic clk = 1'b0;
    logic reset, start;
    logic [AW:0] num_vec;
    logic [2:0] rm_cfg, op_type_cfg;

    logic vec_rd0, vec_rd1, dut_valid0, dut_valid1;
    logic [AW-1:0] vec_addr0, vec_addr1, err_index0, err_index1;
    logic [VW-1:0] vec_data0, vec_data1;
    logic [FLEN-1:0] dut_op1_0, dut_op2_0, dut_op1_1, dut_op2_1;
    logic [2:0] dut_rm0, dut_rm1, dut_op_type0, dut_op_type1;
    logic [FLEN-1:0] dut_result0, dut_result1;
    logic [4:0] dut_flags0, dut_flags1;
    logic busy0, busy1, done0, done1, err_valid0, err_valid1;
    logic [AW:0] vec_count0, vec_count1;
    logic [31:0] err_count0, err_count1;
    logic [FLEN-1:0] err_result0, err_result1, err_expected0, err_expected1;

    logic [VW-1:0] mem [NMAX];
    logic [FLEN-1:0] res_p [LAT1];
    logic [4:0] flg_p [LAT1];
    err_rec_t exp_q[$];
    int checks = 0, failures = 0;
    int bad_idx = -1, vcnt0 = 0;
    int cyc_k, rd_cnt0, dv1_cnt, dv1_run, dv1_max, errp0, errp1, cur_rm, cur_op;

    always #5 clk = ~clk;

    fp_vector_checker #(.FLEN(FLEN), .DUT_LAT(0), .AW(AW)) dut0 (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .rm_cfg(rm_cfg),
        .op_type_cfg(op_type_cfg), .vec_rd(vec_rd0), .vec_addr(vec_addr0), .vec_data(vec_data0),
        .dut_valid(dut_valid0), .dut_op1(dut_op1_0), .dut_op2(dut_op2_0), .dut_rm(dut_rm0),
        .dut_op_type(dut_op_type0), .dut_result(dut_result0), .dut_flags(dut_flags0),
        .busy(busy0), .done(done0), .vec_count(vec_count0), .err_count(err_count0),
        .err_valid(err_valid0), .err_index(err_index0), .err_result(err_result0),
        .err_expected(err_expected0));

    fp_vector_checker #(.FLEN(FLEN), .DUT_LAT(LAT1), .AW(AW)) dut1 (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .rm_cfg(rm_cfg),
        .op_type_cfg(op_type_cfg), .vec_rd(vec_rd1), .vec_addr(vec_addr1), .vec_data(vec_data1),
        .dut_valid(dut_valid1), .dut_op1(dut_op1_1), .dut_op2(dut_op2_1), .dut_rm(dut_rm1),
        .dut_op_type(dut_op_type1), .dut_result(dut_result1), .dut_flags(dut_flags1),
        .busy(busy1), .done(done1), .vec_count(vec_count1), .err_count(err_count1),
        .err_valid(err_valid1), .err_index(err_index1), .err_result(err_result1),
        .err_expected(err_expected1));

    // Vector memory: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        vec_data0 <= vec_rd0 ? mem[vec_addr0] : {VW{1'b1}};
        vec_data1 <= vec_rd1 ? mem[vec_addr1] : {VW{1'b1}};
    end

    // Index of the current dut_valid beat on instance 0
    always @(posedge clk) begin
        if (reset || (start && !busy0)) vcnt0 <= 0;
        else if (dut_valid0) vcnt0 <= vcnt0 + 1;
    end

    always_comb begin
        if (dut_valid0 && (vcnt0 == bad_idx)) dut_result0 = 32'h3f80_0000;
        else dut_result0 = dut_op1_0 ^ dut_op2_0;
        dut_flags0 = dut_op1_0[4:0] ^ dut_op2_0[4:0];
    end

    // Fake unit with LAT1 cycles of latency for instance 1
    always @(posedge clk) begin
        res_p[0] <= dut_op1_1 ^ dut_op2_1;
        flg_p[0] <= dut_op1_1[4:0] ^ dut_op2_1[4:0];
        for (int i = 1; i < LAT1; i++) begin
            res_p[i] <= res_p[i-1];
            flg_p[i] <= flg_p[i-1];
        end
    end
    assign dut_result1 = res_p[LAT1-1];
    assign dut_flags1  = flg_p[LAT1-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one cycle and monitor outputs at the falling edge
    task automatic tick();
        err_rec_t r;
        @(negedge clk);
        cyc_k++;
        if (!reset) begin
            if (err_valid0) begin
                errp0++;
                if (exp_q.size() == 0) begin
                    check("err_unexpected", 64'd1, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("err_index", 64'(err_index0), 64'(r.idx));
                    check("err_result", 64'(err_result0), 64'(r.res));
                    check("err_expected", 64'(err_expected0), 64'(r.exp));
                end
            end
            if (err_valid1) errp1++;
            if (vec_rd0) begin
                check("vec_addr", 64'(vec_addr0), 64'(rd_cnt0));
                rd_cnt0++;
            end
            if (dut_valid0 && vcnt0 < NMAX) begin
                check("dut_op1", 64'(dut_op1_0), 64'(mem[vcnt0][VW-1 -: FLEN]));
                check("dut_op2", 64'(dut_op2_0), 64'(mem[vcnt0][VW-FLEN-1 -: FLEN]));
                check("dut_rm", 64'(dut_rm0), 64'(cur_rm));
                check("dut_op_type", 64'(dut_op_type0), 64'(cur_op));
            end
            if (dut_valid1) begin
                dv1_cnt++;
                dv1_run++;
                if (dv1_run > dv1_max) dv1_max = dv1_run;
            end else begin
                dv1_run = 0;
            end
        end
    endtask

    // Load vectors and push the errors the checker should report
    task automatic fill(input case_t c, output int e0, output int e1);
        logic [31:0] a, b, y;
        logic [7:0] fl;
        err_rec_t r;
        e0 = 0;
        e1 = 0;
        for (int i = 0; i < c.n; i++) begin
            if (c.pat == 0) begin a = 32'h3f80_0000; b = 32'h3f80_0000; end
            else begin a = $urandom; b = $urandom; end
            y  = a ^ b;
            fl = {3'b101, a[4:0] ^ b[4:0]};
            if (i == c.fbad) fl[0] = ~fl[0];
            mem[i] = {a, b, y, fl};
            if (i == c.bad && y != 32'h3f80_0000) begin
                r.idx = i; r.res = 32'h3f80_0000; r.exp = y;
                exp_q.push_back(r);
                e0++;
            end
`ifdef FPCHK_FLAGS_CHECK_EN
            else if (i == c.fbad) begin
                r.idx = i; r.res = y; r.exp = y;
                exp_q.push_back(r);
                e0++;
                e1++;
            end
`endif
        end
    endtask

    task automatic run_case(input case_t c);
        int e0, e1, k0, k1;
        fill(c, e0, e1);
        bad_idx = c.bad;
        rd_cnt0 = 0; dv1_cnt = 0; dv1_run = 0; dv1_max = 0; errp0 = 0; errp1 = 0;
        cur_rm = c.rm; cur_op = c.op;
        k0 = -1; k1 = -1;
        start = 1'b1; num_vec = (AW+1)'(c.n);
        rm_cfg = 3'(c.rm); op_type_cfg = 3'(c.op);
        cyc_k = 0;
        tick();
        start = 1'b0;
        num_vec = (AW+1)'($urandom_range(0, 64));
        rm_cfg = 3'($urandom_range(0, 7));
        op_type_cfg = 3'($urandom_range(0, 7));
        for (int t = 0; t < 300 && (k0 < 0 || k1 < 0); t++) begin
            if (k0 < 0 && done0) k0 = cyc_k;
            if (k1 < 0 && done1) k1 = cyc_k;
            if (c.poke && cyc_k == 2) begin
                start = 1'b1; num_vec = (AW+1)'(2); rm_cfg = 3'd7;
            end else begin
                start = 1'b0;
            end
            if (k0 < 0 || k1 < 0) tick();
        end
        start = 1'b0;
        check("done_latency0", 64'(k0), 64'(c.n == 0 ? 1 : c.n + 3));
        check("done_latency1", 64'(k1), 64'(c.n == 0 ? 1 : c.n + LAT1 + 3));
        check("vec_count0", 64'(vec_count0), 64'(c.n));
        check("vec_count1", 64'(vec_count1), 64'(c.n));
        check("err_count0", 64'(err_count0), 64'(e0));
        check("err_count1", 64'(err_count1), 64'(e1));
        check("err_pulses0", 64'(errp0), 64'(e0));
        check("err_pulses1", 64'(errp1), 64'(e1));
        check("vec_rd_count", 64'(rd_cnt0), 64'(c.n));
        check("dut_valid_count1", 64'(dv1_cnt), 64'(c.n));
        check("dut_valid_burst1", 64'(dv1_max), 64'(c.n));
        check("busy_after_done", 64'({busy0, busy1}), 64'd0);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) tick();
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'(|{vec_rd0, vec_addr0, dut_valid0, dut_op1_0, dut_op2_0, dut_rm0,
                         dut_op_type0, busy0, done0, vec_count0, err_count0, err_valid0,
                         err_index0, err_result0, err_expected0,
                         vec_rd1, dut_valid1, busy1, done1, vec_count1, err_count1,
                         err_valid1, err_index1, err_result1, err_expected1}), 64'd0);
    endtask

    initial begin
        case_t cases[8];
        case_t rc;
        int e0, e1;
        bit hit;
        cases[0] = '{4,  1, 0, 0, -1, -1, 1'b0};
        cases[1] = '{4,  1, 0, 0,  2, -1, 1'b0};
        cases[2] = '{10, 2, 3, 1, -1, -1, 1'b0};
        cases[3] = '{0,  3, 1, 1, -1, -1, 1'b0};
        cases[4] = '{7,  4, 5, 1,  6, -1, 1'b0};
        cases[5] = '{5,  0, 2, 0, -1,  3, 1'b0};
        cases[6] = '{6,  6, 4, 1,  0, -1, 1'b1};
        cases[7] = '{64, 5, 1, 1, 63, -1, 1'b0};

        reset = 1'b1; start = 1'b0; num_vec = '0; rm_cfg = 3'd0; op_type_cfg = 3'd0;
        rd_cnt0 = 0; dv1_cnt = 0; dv1_run = 0; dv1_max = 0; errp0 = 0; errp1 = 0;
        cur_rm = 0; cur_op = 0; cyc_k = 0;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        reset = 1'b0;
        tick();
        check("idle_done", 64'(done0), 64'd0);

        for (int i = 0; i < 8; i++) run_case(cases[i]);

        // Reset in the middle of a run abandons it
        rc = '{10, 2, 6, 1, -1, -1, 1'b0};
        fill(rc, e0, e1);
        bad_idx = -1; cur_rm = 2; cur_op = 6; rd_cnt0 = 0;
        start = 1'b1; num_vec = (AW+1)'(10); rm_cfg = 3'd2; op_type_cfg = 3'd6;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 20 && !hit; t++) begin
            if (vec_rd0 && vec_addr0 == AW'(5)) hit = 1'b1;
            else tick();
        end
        check("reached_vec5", 64'(hit), 64'd1);
        reset = 1'b1;
        tick();
        check_all_zero("midrun_reset_outputs");
        reset = 1'b0;
        exp_q.delete();
        errp0 = 0; errp1 = 0;
        repeat (10) tick();
        check("abandoned_vec_count", 64'({vec_count0, vec_count1}), 64'd0);
        check("abandoned_err_pulses", 64'(errp0 + errp1), 64'd0);
        check("abandoned_dut_valid", 64'({dut_valid0, dut_valid1, busy0, busy1}), 64'd0);
        run_case('{9, 7, 7, 1, 4, -1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
